dma_controller: RTL

Sequences the external device into memory on behalf of the CPU. After the CPU services the device interrupt it issues a command: base address plus 4-word block count. The controller requests the memory bus, reads each 64-bit block from the device by offset, burst-writes it to memory, releases the bus and pulses a completion interrupt. It sits between CPU, external device and memory in the DMA subsystem.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_controller.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the device-to-memory DMA controller.
package dma_pkg;

  localparam int WORD_SIZE      = 16;
  localparam int DATA_SIZE      = 3;
  localparam int DEVICE_BIT_LEN = 2;
  localparam int BLOCK_WORDS    = 4;

  // All-ones offset deselects the device so its data bus floats.
  localparam logic [DEVICE_BIT_LEN-1:0] IDLE_OFFSET = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    WRITE,
    DONE
  } dma_state_t;

endpackage

// File: rtl/dma_controller.sv
// Moves up to DATA_SIZE 4-word blocks from the external device into memory,
// arbitrating for the bus and raising a one-cycle completion interrupt.
module dma_controller
  import dma_pkg::*;
#(
  parameter int WORD_SIZE      = dma_pkg::WORD_SIZE,
  parameter int DATA_SIZE      = dma_pkg::DATA_SIZE,
  parameter int DEVICE_BIT_LEN = dma_pkg::DEVICE_BIT_LEN
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  input  logic [WORD_SIZE-1:0]          cmd_addr,
  input  logic [DEVICE_BIT_LEN-1:0]     cmd_count,
  output logic                          cmd_ready,
  output logic                          bus_request,
  input  logic                          bus_grant,
  output logic [DEVICE_BIT_LEN-1:0]     offset,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] dev_data,
  output logic                          mem_write,
  output logic [WORD_SIZE-1:0]          mem_addr,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] mem_wdata,
  input  logic                          mem_ack,
  output logic                          dma_end,
  output logic                          busy
);

  localparam int CW = DEVICE_BIT_LEN + 1;
  localparam logic [DEVICE_BIT_LEN-1:0] OFF_IDLE = DEVICE_BIT_LEN'(IDLE_OFFSET);

  dma_state_t                state;
  logic [DEVICE_BIT_LEN-1:0] idx;
  logic [CW-1:0]             count_reg;
  logic [CW-1:0]             count_clamped;
  logic                      last_block;

  assign count_clamped = ({1'b0, cmd_count} > CW'(DATA_SIZE)) ? CW'(DATA_SIZE)
                                                             : {1'b0, cmd_count};
  assign last_block    = ((CW'(idx) + CW'(1)) == count_reg);

  // mem_addr and mem_wdata double as the address register and block buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      bus_request <= 1'b0;
      mem_write   <= 1'b0;
      dma_end     <= 1'b0;
      busy        <= 1'b0;
      offset      <= OFF_IDLE;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      idx         <= '0;
      count_reg   <= '0;
    end else begin
      dma_end <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            mem_addr    <= cmd_addr;
            idx         <= '0;
            count_reg   <= count_clamped;
            state       <= REQ;
            cmd_ready   <= 1'b0;
            busy        <= 1'b1;
            bus_request <= (count_clamped != '0);
          end
        end

        REQ: begin
          if (count_reg == '0) begin
            // Empty command: pass through without ever touching the bus.
            state       <= DONE;
            bus_request <= 1'b0;
            dma_end     <= 1'b1;
          end else if (bus_grant) begin
            state  <= LOAD;
            offset <= idx;
          end
        end

        LOAD: begin
          if (!bus_grant) begin
            state  <= REQ;
            offset <= OFF_IDLE;
          end else begin
            mem_wdata <= dev_data;
            mem_write <= 1'b1;
            state     <= WRITE;
          end
        end

        WRITE: begin
          if (mem_ack) begin
            // An ack always completes the block, even if the grant drops with it.
            mem_write <= 1'b0;
            mem_addr  <= mem_addr + WORD_SIZE'(BLOCK_WORDS);
            idx       <= idx + DEVICE_BIT_LEN'(1);
            if (last_block) begin
              state       <= DONE;
              bus_request <= 1'b0;
              dma_end     <= 1'b1;
              offset      <= OFF_IDLE;
            end else if (bus_grant) begin
              state  <= LOAD;
              offset <= idx + DEVICE_BIT_LEN'(1);
            end else begin
              state  <= REQ;
              offset <= OFF_IDLE;
            end
          end else if (!bus_grant) begin
            mem_write <= 1'b0;
            state     <= REQ;
            offset    <= OFF_IDLE;
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          bus_request <= 1'b0;
          mem_write   <= 1'b0;
          busy        <= 1'b0;
          offset      <= OFF_IDLE;
        end
      endcase
    end
  end

endmodule
